// File: rtl/uart_tx_serializer_if.sv
// Upstream write port of the UART transmit serializer: byte strobe in,
// queue status back out.
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_flag;
  logic       fifo_full;
  logic       overflow;

  modport master (output tx_data, tx_flag, input fifo_full, overflow);
  modport slave  (input tx_data, tx_flag, output fifo_full, overflow);
endinterface

// File: rtl/uart_tx_serializer.sv
// RS232 transmit serializer with a 4-entry byte queue, optional parity and
// 1 or 2 stop bits. All outputs are registered.
module uart_tx_serializer #(
  parameter logic [12:0] BAUD_CNT_MAX = 13'd5207,
  parameter logic        PARITY_EN    = 1'b0,
  parameter logic        PARITY_ODD   = 1'b0,
  parameter logic [1:0]  STOP_BITS    = 2'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_serializer_if.slave   tx_if,
  output logic                  tx,
  output logic                  tx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic [12:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [1:0]  stop_cnt, stop_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic        parity_q, parity_nxt;
  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count, count_nxt;
  logic        push, pop, bit_end, tx_nxt;

  assign bit_end = (baud_cnt == BAUD_CNT_MAX);
  // A full queue drops the write even if a pop happens on the same edge.
  assign push    = tx_if.tx_flag && (count != 3'd4);

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt + 13'd1;
    bit_nxt    = bit_cnt;
    stop_nxt   = stop_cnt;
    shift_nxt  = shift_q;
    parity_nxt = parity_q;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (count != '0) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift_q[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = PARITY_EN ? PARITY : STOP;
            stop_nxt  = '0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          stop_nxt  = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_BITS - 2'd1) begin
            if (count != '0) pop = 1'b1;
            else             state_nxt = IDLE;
          end else begin
            stop_nxt = stop_cnt + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bit_end || pop) baud_nxt = '0;

    // Popping from IDLE or from the last stop bit both start a new frame.
    if (pop) begin
      state_nxt  = START;
      shift_nxt  = mem[rd_ptr];
      parity_nxt = (^mem[rd_ptr]) ^ PARITY_ODD;
    end

    count_nxt = count + {2'b00, push} - {2'b00, pop};

    case (state_nxt)
      IDLE:    tx_nxt = 1'b1;
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_cnt         <= '0;
      stop_cnt        <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      tx              <= 1'b1;
      tx_busy         <= 1'b0;
      tx_if.fifo_full <= 1'b0;
      tx_if.overflow  <= 1'b0;
    end else begin
      state           <= state_nxt;
      baud_cnt        <= baud_nxt;
      bit_cnt         <= bit_nxt;
      stop_cnt        <= stop_nxt;
      shift_q         <= shift_nxt;
      parity_q        <= parity_nxt;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count           <= count_nxt;
      tx              <= tx_nxt;
      tx_busy         <= (state_nxt != IDLE) || (count_nxt != '0);
      tx_if.fifo_full <= (count_nxt == 3'd4);
      tx_if.overflow  <= tx_if.tx_flag && (count == 3'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_if.tx_data;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8N1 and 8O2) checked cycle by
// cycle against a queue-based model of the expected line waveform.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int BP          = 8;
  localparam bit D1_PAR_EN   = 1'b1;
  localparam bit D1_PAR_ODD  = 1'b1;
  localparam int D1_STOP     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx0, busy0, tx1, busy1;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();

  uart_tx_serializer #(.BAUD_CNT_MAX(13'd7)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_if(if0), .tx(tx0), .tx_busy(busy0)
  );

  uart_tx_serializer #(.BAUD_CNT_MAX(13'd7), .PARITY_EN(D1_PAR_EN),
                       .PARITY_ODD(D1_PAR_ODD), .STOP_BITS(2'(D1_STOP))) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_if(if1), .tx(tx1), .tx_busy(busy1)
  );

  always #5 clk = ~clk;

  // {tx, tx_busy, fifo_full, overflow}
  logic [3:0] obs   [2];
  logic [3:0] exp_o [2];
  assign obs[0] = {tx0, busy0, if0.fifo_full, if0.overflow};
  assign obs[1] = {tx1, busy1, if1.fifo_full, if1.overflow};

  int n_cmp = 0;
  int n_err = 0;

  // Model: byte queue plus a queue of pending line samples, one per cycle.
  logic [7:0] bq [2][$];
  logic       lq [2][$];

  task automatic push_bit(input int d, input logic v);
    for (int i = 0; i < BP; i++) lq[d].push_back(v);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      bq[d].delete();
      lq[d].delete();
      exp_o[d] = 4'b1000;
    end
  endtask

  task automatic model_edge(input int d, input logic flag, input logic [7:0] data);
    int         occ;
    logic [7:0] b;
    logic       drop, v, in_frame;
    occ  = bq[d].size();
    drop = 1'b0;
    if (lq[d].size() == 0 && occ > 0) begin
      b = bq[d].pop_front();
      push_bit(d, 1'b0);
      for (int i = 0; i < 8; i++) push_bit(d, b[i]);
      if (d == 1 && D1_PAR_EN) push_bit(d, (^b) ^ D1_PAR_ODD);
      for (int s = 0; s < ((d == 1) ? D1_STOP : 1); s++) push_bit(d, 1'b1);
    end
    if (flag) begin
      if (occ < 4) bq[d].push_back(data);
      else         drop = 1'b1;
    end
    if (lq[d].size() > 0) begin
      v = lq[d].pop_front();
      in_frame = 1'b1;
    end else begin
      v = 1'b1;
      in_frame = 1'b0;
    end
    exp_o[d] = {v, in_frame || (bq[d].size() != 0), bq[d].size() == 4, drop};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, if0.tx_flag, if0.tx_data);
    model_edge(1, if1.tx_flag, if1.tx_data);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs[d] !== 4'b1000) begin
        n_err++;
        $display("FAIL reset dut%0d outs got %b want %b", d, obs[d], 4'b1000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] a5 = 8'hA5;
    int busy_n = 0;
    if0.tx_data = a5;
    if0.tx_flag = 1'b1;
    for (int k = 1; k <= 95; k++) begin
      tick();
      if0.tx_flag = 1'b0;
      busy_n += int'(busy0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_o[d]) begin
          n_err++;
          $display("FAIL single dut%0d cyc%0d got %b want %b", d, k, obs[d], exp_o[d]);
        end
      end
      if (k == 2 || (k >= 10 && k < 74 && (k - 10) % 8 == 4)) begin
        n_cmp++;
        if (tx0 !== ((k == 2) ? 1'b0 : a5[(k - 10) / 8])) begin
          n_err++;
          $display("FAIL single_bit cyc%0d got %b want %b", k, tx0,
                   (k == 2) ? 1'b0 : a5[(k - 10) / 8]);
        end
      end
    end
    n_cmp++;
    if (busy_n !== 81) begin
      n_err++;
      $display("FAIL single_busy_len got %0d want %0d", busy_n, 81);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    for (int k = 1; k <= 263; k++) begin
      if0.tx_flag = (k <= 3);
      if0.tx_data = 8'(k);
      tick();
      busy_n += int'(busy0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_o[d]) begin
          n_err++;
          $display("FAIL b2b dut%0d cyc%0d got %b want %b", d, k, obs[d], exp_o[d]);
        end
      end
    end
    if0.tx_flag = 1'b0;
    n_cmp++;
    if (busy_n !== 241) begin
      n_err++;
      $display("FAIL b2b_busy_len got %0d want %0d", busy_n, 241);
    end
  endtask

  task automatic test_overflow();
    int busy_n = 0, ovf_n = 0, full_n = 0;
    for (int k = 1; k <= 430; k++) begin
      if0.tx_flag = (k <= 6);
      if0.tx_data = 8'h30 + 8'(k);
      tick();
      busy_n += int'(busy0);
      ovf_n  += int'(if0.overflow);
      full_n += int'(if0.fifo_full);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_o[d]) begin
          n_err++;
          $display("FAIL overflow dut%0d cyc%0d got %b want %b", d, k, obs[d], exp_o[d]);
        end
      end
    end
    if0.tx_flag = 1'b0;
    n_cmp++;
    if (ovf_n !== 1) begin
      n_err++;
      $display("FAIL ovf_pulses got %0d want %0d", ovf_n, 1);
    end
    n_cmp++;
    if (busy_n !== 401) begin
      n_err++;
      $display("FAIL ovf_busy_len got %0d want %0d", busy_n, 401);
    end
    n_cmp++;
    if (full_n == 0) begin
      n_err++;
      $display("FAIL ovf_full_seen got %0d want >0", full_n);
    end
  endtask

  task automatic test_parity();
    int busy_n = 0;
    if1.tx_data = 8'h07;
    if1.tx_flag = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if1.tx_flag = 1'b0;
      busy_n += int'(busy1);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_o[d]) begin
          n_err++;
          $display("FAIL parity dut%0d cyc%0d got %b want %b", d, k, obs[d], exp_o[d]);
        end
      end
      if (k == 78) begin
        n_cmp++;
        if (tx1 !== 1'b0) begin
          n_err++;
          $display("FAIL parity_bit got %b want %b", tx1, 1'b0);
        end
      end
    end
    n_cmp++;
    if (busy_n !== 97) begin
      n_err++;
      $display("FAIL parity_busy_len got %0d want %0d", busy_n, 97);
    end
  endtask

  task automatic test_random();
    for (int k = 1; k <= 1800; k++) begin
      if0.tx_flag = (k <= 1200) && ($urandom_range(0, 99) < 4);
      if0.tx_data = 8'($urandom);
      if1.tx_flag = (k <= 1200) && ($urandom_range(0, 99) < 3);
      if1.tx_data = 8'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_o[d]) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d got %b want %b", d, k, obs[d], exp_o[d]);
        end
      end
    end
    if0.tx_flag = 1'b0;
    if1.tx_flag = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] bytes [3] = '{8'h3C, 8'hC3, 8'h5A};
    for (int k = 0; k < 33; k++) begin
      if0.tx_flag = (k < 3);
      if0.tx_data = bytes[(k < 3) ? k : 0];
      tick();
    end
    if0.tx_flag = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs[d] !== 4'b1000) begin
        n_err++;
        $display("FAIL async_reset dut%0d got %b want %b", d, obs[d], 4'b1000);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs[d] !== exp_o[d]) begin
          n_err++;
          $display("FAIL post_reset dut%0d cyc%0d got %b want %b", d, k, obs[d], exp_o[d]);
        end
      end
    end
  endtask

  initial begin
    if0.tx_flag = 1'b0;
    if0.tx_data = '0;
    if1.tx_flag = 1'b0;
    if1.tx_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
